// File: rtl/siso_xfer_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// siso_xfer_ctrl_pkg
//
// Shared definitions for the SISO transfer sequencer:
//   - state_t        : sequencer states (IDLE, CLEAR, RUN, HOLD)
//   - DEF_WIDTH      : default word width in bits
//   - DEF_DEPTH      : default number of flops in the attached SISO chain
//   - cnt_width()    : width of the RUN bit counter, $clog2(width+depth)
//                      clamped to at least one bit
// -----------------------------------------------------------------------------
package siso_xfer_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_RUN   = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 4;

    // The counter must reach width+depth-1. A 1-bit counter is the floor so a
    // degenerate width+depth of 1 still yields a legal vector.
    function automatic int cnt_width(input int width, input int depth);
        int w;
        w = $clog2(width + depth);
        return (w < 1) ? 1 : w;
    endfunction

endpackage : siso_xfer_ctrl_pkg

// File: rtl/siso_xfer_ctrl.sv
// -----------------------------------------------------------------------------
// siso_xfer_ctrl
//
// Transfer sequencer that uses an external SISO shift chain as a loopback
// delay line. A word accepted on the tx handshake is serialised onto the
// chain after a one-cycle chain clear; the chain output is captured DEPTH
// cycles later, reassembled, and returned on the rx handshake together with
// a flag telling whether the looped-back word differs from the sent one.
//
// Parameters:
//   WIDTH     - bits per transferred word (>= 1)
//   DEPTH     - flops in the attached SISO chain (>= 1)
//   MSB_FIRST - 1: bit WIDTH-1 goes out first, 0: bit 0 goes out first
//
// Ports:
//   clk       in   clock, everything updates on its rising edge
//   clear_n   in   asynchronous active-low reset
//   tx_data   in   word to send, sampled on acceptance
//   tx_valid  in   tx_data valid
//   tx_ready  out  controller can accept (only in IDLE)
//   sr_clear  out  active-high clear to the chain (registered)
//   sr_s_in   out  serial data into the chain (registered)
//   sr_s_out  in   serial data from the chain's last stage
//   rx_data   out  reassembled received word
//   rx_valid  out  rx_data / rx_error valid, held until rx_ready
//   rx_ready  in   consumer takes the result
//   rx_error  out  received word differs from the accepted word
//   busy      out  high in every state except IDLE
// -----------------------------------------------------------------------------
module siso_xfer_ctrl
    import siso_xfer_ctrl_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int DEPTH     = DEF_DEPTH,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             clear_n,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic             sr_clear,
    output logic             sr_s_in,
    input  logic             sr_s_out,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
    input  logic             rx_ready,
    output logic             rx_error,
    output logic             busy
);

    localparam int CNT_W = cnt_width(WIDTH, DEPTH);

    // Last RUN cycle, and first RUN cycle whose chain output carries word data.
    localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(WIDTH + DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_CAPTURE = CNT_W'(DEPTH);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] tx_word;   // accepted word, kept intact for the compare
    logic [WIDTH-1:0] sh_out;    // drains one bit per cycle onto the chain
    logic [WIDTH-1:0] sh_in;     // fills one bit per cycle from the chain

    logic             out_bit;
    logic [WIDTH-1:0] sh_out_next;
    logic [WIDTH-1:0] sh_in_next;

    // Shift-order helpers. Shifting sh_out fills zeros behind the word, so once
    // all WIDTH bits have left, sr_s_in naturally carries 0 for the remaining
    // DEPTH cycles of RUN without any extra comparison on cnt.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can
        // leave it unassigned and infer a latch.
        out_bit     = 1'b0;
        sh_out_next = '0;
        sh_in_next  = '0;
        if (MSB_FIRST) begin
            out_bit     = sh_out[WIDTH-1];
            sh_out_next = sh_out << 1;
            sh_in_next  = (sh_in << 1) | WIDTH'(sr_s_out);
        end else begin
            out_bit     = sh_out[0];
            sh_out_next = sh_out >> 1;
            sh_in_next  = (sh_in >> 1) | (WIDTH'(sr_s_out) << (WIDTH - 1));
        end
    end

    // The capture register is the result register; after exactly WIDTH
    // captures it holds the whole received word and stays put during HOLD.
    assign rx_data = sh_in;

    // Sequencer: state, counter, data registers and all registered outputs.
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            // NOTE: the data registers are reset too, not just the control
            // state, because rx_data is taken straight from sh_in and must
            // read 0 during and after reset.
            state    <= ST_IDLE;
            cnt      <= '0;
            tx_word  <= '0;
            sh_out   <= '0;
            sh_in    <= '0;
            tx_ready <= 1'b0;
            sr_clear <= 1'b1;  // keep the chain cleared while in reset
            sr_s_in  <= 1'b0;
            rx_valid <= 1'b0;
            rx_error <= 1'b0;
            busy     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments only, so every branch below reads
            // the pre-edge value of each register regardless of statement order.
            unique case (state)
                ST_IDLE: begin
                    tx_ready <= 1'b1;
                    sr_clear <= 1'b0;
                    sr_s_in  <= 1'b0;
                    if (tx_valid && tx_ready) begin
                        tx_word  <= tx_data;
                        sh_out   <= tx_data;
                        tx_ready <= 1'b0;
                        sr_clear <= 1'b1;
                        busy     <= 1'b1;
                        state    <= ST_CLEAR;
                    end
                end

                ST_CLEAR: begin
                    // The chain is cleared during this cycle; the first word
                    // bit is presented from the edge that enters RUN.
                    sr_clear <= 1'b0;
                    cnt      <= '0;
                    sr_s_in  <= out_bit;
                    sh_out   <= sh_out_next;
                    state    <= ST_RUN;
                end

                ST_RUN: begin
                    sr_s_in <= out_bit;
                    sh_out  <= sh_out_next;

                    // Bit k-DEPTH reaches the chain output during cycle k.
                    if (cnt >= CNT_CAPTURE) begin
                        sh_in <= sh_in_next;
                    end

                    if (cnt == CNT_LAST) begin
                        // The last capture happens on this same edge, so the
                        // compare uses the word including that final bit.
                        rx_error <= (sh_in_next != tx_word);
                        rx_valid <= 1'b1;
                        sr_s_in  <= 1'b0;
                        cnt      <= '0;
                        state    <= ST_HOLD;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                ST_HOLD: begin
                    if (rx_valid && rx_ready) begin
                        rx_valid <= 1'b0;
                        busy     <= 1'b0;
                        tx_ready <= 1'b1;
                        state    <= ST_IDLE;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule : siso_xfer_ctrl

// File: tb/tb_siso_xfer_ctrl.sv
// -----------------------------------------------------------------------------
// tb_siso_xfer_ctrl
//
// Two sequencers, each looped through its own 4-stage SISO chain: one with
// MSB_FIRST=1 (most scenarios) and one with MSB_FIRST=0. Expected results are
// queued when a word is sent and popped when the sequencer completes an rx
// handshake.
// -----------------------------------------------------------------------------
module tb_siso_xfer_ctrl;

    typedef struct {
        logic [7:0] data;
        logic       err;
    } exp_t;

    logic clk     = 1'b0;
    logic clear_n = 1'b1;

    always #5 clk = ~clk;

    int cyc   = 0;
    int total = 0;
    int bad   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // MSB-first instance
    logic [7:0] tx_data  = 8'h00;
    logic       tx_valid = 1'b0;
    logic       rx_ready = 1'b1;
    logic       tx_ready, sr_clear, sr_s_in, sr_s_out, rx_valid, rx_error, busy;
    logic [7:0] rx_data;
    logic [3:0] chain;
    logic       stuck = 1'b0;

    // LSB-first instance
    logic [7:0] tx_data_l  = 8'h00;
    logic       tx_valid_l = 1'b0;
    logic       rx_ready_l = 1'b1;
    logic       tx_ready_l, sr_clear_l, sr_s_in_l, sr_s_out_l, rx_valid_l, rx_error_l, busy_l;
    logic [7:0] rx_data_l;
    logic [3:0] chain_l;

    exp_t q[$];
    exp_t q_l[$];
    exp_t mon_e;
    exp_t mon_e_l;

    siso_xfer_ctrl #(.WIDTH(8), .DEPTH(4), .MSB_FIRST(1'b1)) dut (
        .clk(clk), .clear_n(clear_n),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .sr_clear(sr_clear), .sr_s_in(sr_s_in), .sr_s_out(sr_s_out),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .rx_error(rx_error), .busy(busy)
    );

    siso_xfer_ctrl #(.WIDTH(8), .DEPTH(4), .MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .clear_n(clear_n),
        .tx_data(tx_data_l), .tx_valid(tx_valid_l), .tx_ready(tx_ready_l),
        .sr_clear(sr_clear_l), .sr_s_in(sr_s_in_l), .sr_s_out(sr_s_out_l),
        .rx_data(rx_data_l), .rx_valid(rx_valid_l), .rx_ready(rx_ready_l),
        .rx_error(rx_error_l), .busy(busy_l)
    );

    // 4-bit SISO chains with synchronous active-high clear.
    always @(posedge clk) begin
        if (sr_clear) chain <= 4'b0000;
        else          chain <= {chain[2:0], sr_s_in};
        if (sr_clear_l) chain_l <= 4'b0000;
        else            chain_l <= {chain_l[2:0], sr_s_in_l};
    end

    assign sr_s_out   = stuck ? 1'b0 : chain[3];
    assign sr_s_out_l = chain_l[3];

    // Scoreboard monitors: a handshake is seen mid-cycle and completes on the
    // following rising edge.
    always @(negedge clk) begin
        if (clear_n && rx_valid && rx_ready) begin
            total++;
            if (q.size() == 0) begin
                bad++;
                $display("FAIL rx_unexpected: got rx_data=%h with no word outstanding", rx_data);
            end else begin
                mon_e = q.pop_front();
                if (rx_data !== mon_e.data || rx_error !== mon_e.err) begin
                    bad++;
                    $display("FAIL rx_result: got data=%h err=%b want data=%h err=%b",
                             rx_data, rx_error, mon_e.data, mon_e.err);
                end
            end
        end
        if (clear_n && rx_valid_l && rx_ready_l) begin
            total++;
            if (q_l.size() == 0) begin
                bad++;
                $display("FAIL rx_l_unexpected: got rx_data=%h with no word outstanding", rx_data_l);
            end else begin
                mon_e_l = q_l.pop_front();
                if (rx_data_l !== mon_e_l.data || rx_error_l !== mon_e_l.err) begin
                    bad++;
                    $display("FAIL rx_l_result: got data=%h err=%b want data=%h err=%b",
                             rx_data_l, rx_error_l, mon_e_l.data, mon_e_l.err);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a word to the MSB-first instance; returns #1 after the accept edge.
    task automatic send(input logic [7:0] data, input logic [7:0] exp_data,
                        input logic exp_err, input bit push);
        int waited;
        exp_t e;
        waited = 0;
        while (tx_ready !== 1'b1 && waited < 50) begin
            tick();
            waited++;
        end
        total++;
        if (tx_ready !== 1'b1) begin
            bad++;
            $display("FAIL send_ready_timeout: got tx_ready=%b want 1", tx_ready);
        end
        tx_data  = data;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        if (push) begin
            e.data = exp_data;
            e.err  = exp_err;
            q.push_back(e);
        end
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((q.size() != 0 || busy !== 1'b0) && n < 100) begin
            tick();
            n++;
        end
        total++;
        if (q.size() != 0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL drain_timeout: got pending=%0d busy=%b want 0 0", q.size(), busy);
        end
    endtask

    task automatic test_reset();
        #2;
        clear_n = 1'b0;
        tick();
        tick();
        total++;
        if ({sr_clear, tx_ready, busy, rx_valid, sr_s_in, rx_error} !== 6'b100000 ||
            rx_data !== 8'h00) begin
            bad++;
            $display("FAIL reset_values: got clr=%b rdy=%b busy=%b rxv=%b sin=%b err=%b data=%h want 1 0 0 0 0 0 00",
                     sr_clear, tx_ready, busy, rx_valid, sr_s_in, rx_error, rx_data);
        end
        clear_n = 1'b1;
        tick();
        total++;
        if (tx_ready !== 1'b1 || sr_clear !== 1'b0 || tx_ready_l !== 1'b1) begin
            bad++;
            $display("FAIL reset_release: got rdy=%b clr=%b rdy_l=%b want 1 0 1",
                     tx_ready, sr_clear, tx_ready_l);
        end
    endtask

    task automatic test_basic();
        logic [7:0] w;
        logic       exp_bit;
        w = 8'hA5;
        rx_ready = 1'b1;
        send(w, w, 1'b0, 1'b1);
        total++;
        if (sr_clear !== 1'b1 || busy !== 1'b1 || tx_ready !== 1'b0) begin
            bad++;
            $display("FAIL basic_clear: got clr=%b busy=%b rdy=%b want 1 1 0", sr_clear, busy, tx_ready);
        end
        for (int i = 0; i < 12; i++) begin
            tick();
            exp_bit = (i < 8) ? w[7-i] : 1'b0;
            total++;
            if (sr_s_in !== exp_bit || rx_valid !== 1'b0 || sr_clear !== 1'b0) begin
                bad++;
                $display("FAIL basic_serial E%0d: got sin=%b rxv=%b clr=%b want %b 0 0",
                         i + 1, sr_s_in, rx_valid, sr_clear, exp_bit);
            end
        end
        tick();
        total++;
        if (rx_valid !== 1'b1) begin
            bad++;
            $display("FAIL basic_rx_rise: got rx_valid=%b want 1 after E13", rx_valid);
        end
        tick();
        total++;
        if (rx_valid !== 1'b0 || tx_ready !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL basic_rx_fall: got rxv=%b rdy=%b busy=%b want 0 1 0", rx_valid, tx_ready, busy);
        end
        wait_drain();
    endtask

    task automatic test_back_to_back();
        logic [7:0] vals [3];
        int   acc_cyc [3];
        int   n, extra;
        bit   pr, done;
        exp_t e;
        vals[0] = 8'h00; vals[1] = 8'hFF; vals[2] = 8'h3C;
        n = 0; extra = 0; done = 1'b0;
        rx_ready = 1'b1;
        tx_data  = vals[0];
        tx_valid = 1'b1;
        for (int c = 0; c < 200 && !done; c++) begin
            pr = tx_ready;
            tick();
            if (pr && tx_valid) begin
                if (n < 3) begin
                    acc_cyc[n] = cyc;
                    e.data = vals[n];
                    e.err  = 1'b0;
                    q.push_back(e);
                    n++;
                    tx_data = (n < 3) ? vals[n] : 8'hEE;
                end else begin
                    extra++;
                end
            end
            if (n == 3 && cyc - acc_cyc[2] >= 10) done = 1'b1;
        end
        tx_valid = 1'b0;
        total++;
        if (n != 3 || extra != 0) begin
            bad++;
            $display("FAIL b2b_accepts: got accepted=%0d extra=%0d want 3 0", n, extra);
        end
        for (int i = 1; i < n; i++) begin
            total++;
            if (acc_cyc[i] - acc_cyc[i-1] != 15) begin
                bad++;
                $display("FAIL b2b_interval %0d: got %0d cycles want 15", i, acc_cyc[i] - acc_cyc[i-1]);
            end
        end
        wait_drain();
    endtask

    task automatic test_backpressure();
        int n;
        rx_ready = 1'b0;
        send(8'h81, 8'h81, 1'b0, 1'b1);
        n = 0;
        while (rx_valid !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        total++;
        if (rx_valid !== 1'b1 || n != 13) begin
            bad++;
            $display("FAIL bp_rise: got rxv=%b after %0d cycles want 1 after 13", rx_valid, n);
        end
        for (int i = 0; i < 10; i++) begin
            tick();
            total++;
            if (rx_valid !== 1'b1 || rx_data !== 8'h81 || rx_error !== 1'b0 || tx_ready !== 1'b0) begin
                bad++;
                $display("FAIL bp_hold %0d: got rxv=%b data=%h err=%b rdy=%b want 1 81 0 0",
                         i, rx_valid, rx_data, rx_error, tx_ready);
            end
        end
        rx_ready = 1'b1;
        tick();
        total++;
        if (rx_valid !== 1'b0 || busy !== 1'b0 || tx_ready !== 1'b1) begin
            bad++;
            $display("FAIL bp_release: got rxv=%b busy=%b rdy=%b want 0 0 1", rx_valid, busy, tx_ready);
        end
        wait_drain();
    endtask

    task automatic test_fault();
        stuck = 1'b1;
        rx_ready = 1'b1;
        send(8'h5A, 8'h00, 1'b1, 1'b1);
        wait_drain();
        stuck = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        rx_ready = 1'b1;
        send(8'hC3, 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) tick();  // now in RUN with cnt=5
        clear_n = 1'b0;
        #1;
        total++;
        if ({sr_clear, tx_ready, busy, rx_valid, sr_s_in, rx_error} !== 6'b100000 ||
            rx_data !== 8'h00) begin
            bad++;
            $display("FAIL midrun_reset: got clr=%b rdy=%b busy=%b rxv=%b sin=%b err=%b data=%h want 1 0 0 0 0 0 00",
                     sr_clear, tx_ready, busy, rx_valid, sr_s_in, rx_error, rx_data);
        end
        tick();
        tick();
        clear_n = 1'b1;
        tick();
        total++;
        if (tx_ready !== 1'b1 || sr_clear !== 1'b0) begin
            bad++;
            $display("FAIL midrun_release: got rdy=%b clr=%b want 1 0", tx_ready, sr_clear);
        end
        for (int i = 0; i < 20; i++) begin
            tick();
            total++;
            if (rx_valid !== 1'b0 || busy !== 1'b0) begin
                bad++;
                $display("FAIL midrun_discard %0d: got rxv=%b busy=%b want 0 0", i, rx_valid, busy);
            end
        end
        send(8'h12, 8'h12, 1'b0, 1'b1);
        wait_drain();
    endtask

    task automatic test_lsb_first();
        exp_t e;
        logic exp_bit;
        int   n;
        rx_ready_l = 1'b1;
        total++;
        if (tx_ready_l !== 1'b1) begin
            bad++;
            $display("FAIL lsb_ready: got tx_ready=%b want 1", tx_ready_l);
        end
        tx_data_l  = 8'h01;
        tx_valid_l = 1'b1;
        tick();
        tx_valid_l = 1'b0;
        e.data = 8'h01;
        e.err  = 1'b0;
        q_l.push_back(e);
        for (int i = 0; i < 12; i++) begin
            tick();
            exp_bit = (i == 0);
            total++;
            if (sr_s_in_l !== exp_bit) begin
                bad++;
                $display("FAIL lsb_serial cnt=%0d: got sin=%b want %b", i, sr_s_in_l, exp_bit);
            end
        end
        n = 0;
        while ((q_l.size() != 0 || busy_l !== 1'b0) && n < 50) begin
            tick();
            n++;
        end
        total++;
        if (q_l.size() != 0 || busy_l !== 1'b0) begin
            bad++;
            $display("FAIL lsb_drain: got pending=%0d busy=%b want 0 0", q_l.size(), busy_l);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_backpressure();
        test_fault();
        test_reset_mid_run();
        test_lsb_first();
        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_siso_xfer_ctrl

// File: doc/siso_xfer_ctrl.md
# siso_xfer_ctrl

Transfer sequencer for the 4-stage serial-in/serial-out shift register. It does four things in order:
- accepts a parallel word over a valid/ready handshake;
- clears the shift chain;
- drives the word onto the chain's serial input one bit per clock;
- captures the chain's serial output after the chain latency and returns the received word with a mismatch flag.

It uses the chain as a loopback delay line and self-test path.

## Interface
- `WIDTH`, default 8: bits per transferred word (≥1).
- `DEPTH`, default 4: number of flops in the attached SISO chain (≥1).
- `MSB_FIRST`, default 1: 1 = bit `WIDTH-1` shifted first; 0 = bit 0 first.

Ports:
- `clk` — in, 1: single clock; all state updates on its rising edge.
- `clear_n` — in, 1: reset, asynchronous, active-low.
- `tx_data` — in, WIDTH: word to send; sampled on acceptance.
- `tx_valid` — in, 1: `tx_data` valid.
- `tx_ready` — out, 1: controller can accept; high only in IDLE.
- `sr_clear` — out, 1: active-high clear to the SISO chain; registered.
- `sr_s_in` — out, 1: serial data into the chain; registered.
- `sr_s_out` — in, 1: serial data from the chain's last stage.
- `rx_data` — out, WIDTH: reassembled received word.
- `rx_valid` — out, 1: `rx_data`/`rx_error` valid; held until `rx_ready`.
- `rx_ready` — in, 1: consumer takes the result.
- `rx_error` — out, 1: `rx_data` ≠ accepted `tx_data`.
- `busy` — out, 1: high in every state except IDLE.

## Operation
- States: IDLE, CLEAR, RUN, HOLD.
- IDLE:
  - `tx_ready`=1; `sr_s_in`=0; `sr_clear`=0.
  - `tx_valid`&&`tx_ready` latches `tx_data` into a shift-out register and goes to CLEAR.
- CLEAR:
  - Lasts exactly one cycle with `sr_clear`=1, then RUN.
  - Bit counter `cnt` loads 0.
- RUN:
  - Lasts exactly `WIDTH+DEPTH` cycles. `cnt` counts 0 to `WIDTH+DEPTH-1`, width `$clog2(WIDTH+DEPTH)`, minimum 1.
  - During cycle `cnt`=k, `sr_s_in` carries word bit k (in shift order) for k<`WIDTH`, else 0.
  - At the end of cycle `cnt`=k with k≥`DEPTH`, `sr_s_out` is captured as received bit k−`DEPTH`, in the same order.
  - After the cycle with `cnt`=`WIDTH+DEPTH-1`, go to HOLD.
- HOLD:
  - `rx_valid`=1. `rx_data` and `rx_error` are stable for the whole of HOLD.
  - `rx_valid`&&`rx_ready` returns to IDLE.
- `rx_error` is computed once, on the HOLD-entry edge, from the full captured word against the latched word.
- `tx_valid` is ignored outside IDLE. A new transfer cannot start until the result is consumed; there is no overlap.
- `tx_data` may change after acceptance without effect.

## Timing
Edges are numbered from the accepting edge E0.
- CLEAR occupies E0→E1.
- RUN `cnt`=k occupies E(k+1)→E(k+2).
- `sr_s_in` bit i is valid E(i+1)→E(i+2).
- Bit i is captured at E(i+DEPTH+2).
- `rx_valid` rises after E(`WIDTH+DEPTH`+1), i.e. E13 for the defaults. End-to-end latency is `WIDTH+DEPTH+1` cycles.
- If `rx_ready` is already high on HOLD entry: `rx_valid` lasts 1 cycle; IDLE and `tx_ready` follow the next edge.
- Best-case accept-to-accept interval is `WIDTH+DEPTH+3` cycles.
- Reset values (`clear_n`=0, any time including mid-RUN or HOLD):
  - state IDLE, `cnt`=0.
  - `sr_clear`=1 (holds the chain cleared during reset).
  - `sr_s_in`=0, `rx_data`=0, `rx_valid`=0, `rx_error`=0, `busy`=0.
  - `tx_ready`=0 during reset, then 1 from the first edge after release, when `sr_clear` also drops to 0.
- A partially shifted word is discarded on reset; no result is produced for it.

## Structure
- A shared package holds:
  - the state enum (IDLE/CLEAR/RUN/HOLD);
  - defaults for `WIDTH` and `DEPTH`;
  - a `cnt` width function, `$clog2(WIDTH+DEPTH)` clamped to ≥1.
- No sub-module. Shift-out register, shift-in register, counter and FSM live in one module.
- The bench instantiates the existing 4-bit SISO shift register as the chain, with `sr_clear` driving its clear input.

## Test plan
Bench config: `WIDTH`=8, `DEPTH`=4, `MSB_FIRST`=1, real 4-stage chain attached.
1. Send 0xA5 with `rx_ready` tied high:
   - `sr_s_in` sequence is 1,0,1,0,0,1,0,1 over E1..E8, then 0s.
   - `rx_valid` is high for exactly one cycle after E13.
   - `rx_data`=0xA5, `rx_error`=0.
2. Back-to-back sends 0x00, 0xFF, 0x3C:
   - each is accepted only when `tx_ready`=1, 15 cycles apart;
   - each returns the same value with `rx_error`=0;
   - `tx_valid` held high during `busy` causes no extra accept.
3. Backpressure: send 0x81 with `rx_ready` low for 10 cycles after `rx_valid` rises:
   - `rx_valid`, `rx_data`=0x81 and `rx_error` are stable throughout;
   - `tx_ready` stays 0;
   - IDLE follows the edge on which `rx_ready` goes high.
4. Fault injection: force `sr_s_out` stuck-at-0, send 0x5A:
   - `rx_data`=0x00, `rx_error`=1.
5. Reset mid-RUN: pull `clear_n` low at `cnt`=5 of a 0xC3 transfer:
   - outputs take their reset values immediately;
   - no `rx_valid` is produced;
   - after release, a send of 0x12 completes correctly.
6. `MSB_FIRST`=0: send 0x01:
   - `sr_s_in` is 1 during `cnt`=0 only;
   - `rx_data`=0x01, `rx_error`=0.
